up_dn_cmd_ctrl: RTL and testbench



---
 rtl/up_dn_cmd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_up_dn_cmd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/up_dn_cmd_ctrl.sv
// up_dn_cmd_ctrl: button front end for the 5-bit up/down counter.
// Synchronises and debounces the Up/Down/Load buttons, generates single-cycle
// commands with auto-repeat on Up/Down, arbitrates Load > Down > Up and drops
// commands the counter would ignore at its High/Low limits.
module up_dn_cmd_ctrl #(
    parameter int WIDTH        = 5,
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Btn_Up,
    input  logic             Btn_Down,
    input  logic             Btn_Load,
    input  logic [WIDTH-1:0] Sw_Val,
    input  logic             High,
    input  logic             Low,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic [WIDTH-1:0] In
);

    localparam int CW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMR_DELAY = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] TMR_RATE  = TW'(REPEAT_RATE);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RPT   = 2'd2
    } rpt_state_t;

    // Button index: 0 = up, 1 = down, 2 = load
    logic [2:0] btn_raw;
    logic [2:0] sync_p0;
    logic [2:0] sync_p1;
    logic [2:0] filt_p2;
    logic       ld_filt_d;
    logic       ld_req;
    logic [1:0] rpt_req;
    logic       dn_ok;
    logic       up_ok;

    assign btn_raw = {Btn_Load, Btn_Down, Btn_Up};

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: filtered level flips only after DEB_CYCLES consecutive disagreeing cycles
    for (genvar b = 0; b < 3; b++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          filt_q;

        // Debounce counter and filtered level for one button
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync_p1[b] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                cnt_q  <= '0;
                filt_q <= ~filt_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign filt_p2[b] = filt_q;
    end

    // Previous filtered Load level, so a load request fires once per press
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ld_filt_d <= 1'b0;
        end else begin
            ld_filt_d <= filt_p2[2];
        end
    end

    assign ld_req = filt_p2[2] & ~ld_filt_d;

    // Auto-repeat FSM for Up (r=0) and Down (r=1); timers ignore arbitration outcome
    for (genvar r = 0; r < 2; r++) begin : g_rpt
        rpt_state_t    st_q;
        rpt_state_t    st_d;
        logic [TW-1:0] tmr_q;
        logic [TW-1:0] tmr_d;
        logic          req;

        // State and timer registers
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                st_q  <= S_IDLE;
                tmr_q <= '0;
            end else begin
                st_q  <= st_d;
                tmr_q <= tmr_d;
            end
        end

        // Next state, timer reload and request generation
        always_comb begin
            st_d  = st_q;
            tmr_d = tmr_q;
            req   = 1'b0;
            case (st_q)
                S_IDLE: begin
                    // Outside IDLE the filtered level is always high, so a high
                    // level seen here is the rising edge of a new press.
                    if (filt_p2[r]) begin
                        req   = 1'b1;
                        tmr_d = TMR_DELAY;
                        st_d  = S_FIRST;
                    end
                end
                S_FIRST, S_RPT: begin
                    if (!filt_p2[r]) begin
                        tmr_d = '0;
                        st_d  = S_IDLE;
                    end else if (tmr_q == TMR_ONE) begin
                        req   = 1'b1;
                        tmr_d = TMR_RATE;
                        st_d  = S_RPT;
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end
                default: begin
                    tmr_d = '0;
                    st_d  = S_IDLE;
                end
            endcase
        end

        assign rpt_req[r] = req;
    end

    // A suppressed Down does not block an Up request in the same cycle
    assign dn_ok = rpt_req[1] & ~Low;
    assign up_ok = rpt_req[0] & ~High;

    // Stage p3: registered arbitration, Load > Down > Up; In captures Sw_Val on load
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Load <= 1'b0;
            Down <= 1'b0;
            Up   <= 1'b0;
            In   <= '0;
        end else begin
            Load <= ld_req;
            Down <= ~ld_req & dn_ok;
            Up   <= ~ld_req & ~dn_ok & up_ok;
            if (ld_req) begin
                In <= Sw_Val;
            end
        end
    end

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// tb_up_dn_cmd_ctrl: directed stimulus with a scoreboard of expected command
// pulses (absolute clock edge, kind, load value) checked by a separate monitor.
module tb_up_dn_cmd_ctrl;

    localparam logic [2:0] K_UP   = 3'b001;
    localparam logic [2:0] K_DOWN = 3'b010;
    localparam logic [2:0] K_LOAD = 3'b100;

    logic       CLK;
    logic       RST;
    logic       Btn_Up;
    logic       Btn_Down;
    logic       Btn_Load;
    logic [4:0] Sw_Val;
    logic       High;
    logic       Low;
    logic       Load;
    logic       Up;
    logic       Down;
    logic [4:0] In;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [4:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   total;
    int   passed;
    int   e0;

    up_dn_cmd_ctrl #(
        .WIDTH       (5),
        .DEB_CYCLES  (4),
        .REPEAT_DELAY(16),
        .REPEAT_RATE (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Btn_Up  (Btn_Up),
        .Btn_Down(Btn_Down),
        .Btn_Load(Btn_Load),
        .Sw_Val  (Sw_Val),
        .High    (High),
        .Low     (Low),
        .Load    (Load),
        .Up      (Up),
        .Down    (Down),
        .In      (In)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Absolute edge counter: value equals the number of the latest rising edge
    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input logic [2:0] k, input logic [4:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: every presented command is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (Load || Up || Down) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_pulse: got Load=%0b Down=%0b Up=%0b at edge %0d, expected none",
                             Load, Down, Up, cyc);
                end else begin
                    e = q.pop_front();
                    chk("pulse_edge", cyc, e.cyc);
                    chk("pulse_kind", int'({Load, Down, Up}), int'(e.kind));
                    if (e.kind == K_LOAD) chk("load_value", int'(In), int'(e.val));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total    = 0;
        passed   = 0;
        RST      = 1'b0;
        Btn_Up   = 1'b0;
        Btn_Down = 1'b0;
        Btn_Load = 1'b0;
        Sw_Val   = 5'h00;
        High     = 1'b0;
        Low      = 1'b0;
        #1;
        chk("reset_load", int'(Load), 0);
        chk("reset_up",   int'(Up),   0);
        chk("reset_down", int'(Down), 0);
        chk("reset_in",   int'(In),   0);
        tick(2);
        RST = 1'b1;
        tick(3);

        // Single press held 10 cycles: one Up pulse six edges after first sample
        e0 = cyc + 1;
        Btn_Up = 1'b1;
        push(e0 + 6, K_UP, 5'h00);
        tick(10);
        Btn_Up = 1'b0;
        tick(30);

        // 3-cycle glitch is filtered out
        Btn_Down = 1'b1;
        tick(3);
        Btn_Down = 1'b0;
        tick(20);

        // 4-cycle glitch passes the filter exactly once
        e0 = cyc + 1;
        Btn_Down = 1'b1;
        push(e0 + 6, K_DOWN, 5'h00);
        tick(4);
        Btn_Down = 1'b0;
        tick(30);

        // Long hold: initial pulse, first repeat after 16, then every 8;
        // released so the debounced fall lands before the edge-62 repeat
        e0 = cyc + 1;
        Btn_Up = 1'b1;
        push(e0 + 6,  K_UP, 5'h00);
        push(e0 + 22, K_UP, 5'h00);
        push(e0 + 30, K_UP, 5'h00);
        push(e0 + 38, K_UP, 5'h00);
        push(e0 + 46, K_UP, 5'h00);
        push(e0 + 54, K_UP, 5'h00);
        tick(56);
        Btn_Up = 1'b0;
        tick(30);

        // Load beats Up on the same cycle and captures Sw_Val
        Sw_Val = 5'h13;
        e0 = cyc + 1;
        Btn_Load = 1'b1;
        Btn_Up   = 1'b1;
        push(e0 + 6, K_LOAD, 5'h13);
        tick(10);
        Btn_Load = 1'b0;
        Btn_Up   = 1'b0;
        tick(20);
        Sw_Val = 5'h02;
        tick(3);
        chk("in_hold", int'(In), 8'h13);

        // Down held with Low=1: pulses at 6 and 22 dropped, repeat at 30 survives
        Low = 1'b1;
        e0 = cyc + 1;
        Btn_Down = 1'b1;
        tick(25);
        Low = 1'b0;
        push(e0 + 30, K_DOWN, 5'h00);
        tick(7);
        Btn_Down = 1'b0;
        tick(30);

        // Up held with High=1: nothing may be issued
        High = 1'b1;
        Btn_Up = 1'b1;
        tick(30);
        Btn_Up = 1'b0;
        tick(20);
        High = 1'b0;

        // Reset mid-hold: outputs clear at once, press is re-seen after release
        e0 = cyc + 1;
        Btn_Up = 1'b1;
        push(e0 + 6, K_UP, 5'h00);
        tick(7);
        RST = 1'b0;
        #1;
        chk("async_rst_up",   int'(Up),   0);
        chk("async_rst_load", int'(Load), 0);
        chk("async_rst_down", int'(Down), 0);
        chk("async_rst_in",   int'(In),   0);
        tick(1);
        RST = 1'b1;
        push(e0 + 14, K_UP, 5'h00);
        tick(12);
        Btn_Up = 1'b0;
        tick(30);

        chk("missing_pulses", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
